pipe_stage_skid: RTL and testbench

- Parametrised, elastic successor to the fixed ID/EX-style pipeline register.
- Sits between any two processor pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Uses a valid/ready handshake with a 2-entry skid buffer, so in_ready_o is registered and breaks the backpressure timing path.
- Adds stall (backpressure), flush with control-bubble insertion, and occupancy reporting. The old register had none of these.

---
 rtl/pipe_stage_skid.sv | 108 ++++++++++
 tb/tb_pipe_stage_skid.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: elastic pipeline register with a 2-entry skid buffer.
// Valid/ready handshake on both sides. in_ready_o comes straight from a flop,
// so downstream backpressure never reaches upstream combinationally.
// Control bits read as zero whenever the held entry is invalid (control bubble).
// Optional macro PIPE_SKID_ZERO_PAYLOAD_EN: also zero the payload registers of
// entries that become invalid, so out_data_o is 0 whenever out_valid_o is 0.
module pipe_stage_skid #(
  parameter int unsigned CTRL_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 128
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [CTRL_WIDTH-1:0] in_ctrl_i,
  input  logic [DATA_WIDTH-1:0] in_data_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [CTRL_WIDTH-1:0] out_ctrl_o,
  output logic [DATA_WIDTH-1:0] out_data_o,
  output logic [1:0]            occupancy_o
);

`ifdef PIPE_SKID_ZERO_PAYLOAD_EN
  localparam bit ZERO_PAYLOAD = 1'b1;
`else
  localparam bit ZERO_PAYLOAD = 1'b0;
`endif

  logic                  main_valid;
  logic                  skid_valid;
  logic                  in_ready_q;
  logic [CTRL_WIDTH-1:0] main_ctrl;
  logic [CTRL_WIDTH-1:0] skid_ctrl;
  logic [DATA_WIDTH-1:0] main_data;
  logic [DATA_WIDTH-1:0] skid_data;
  logic                  in_fire;
  logic                  out_fire;

  assign in_fire  = in_valid_i & in_ready_q;
  assign out_fire = main_valid & out_ready_i;

  // Valid bits, control bits and the registered ready flag.
  // The skid is only ever filled while main is full, so skid_valid alone decides
  // ready, and a full skid blocks input in the cycle it moves into main.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_ctrl  <= '0;
      skid_ctrl  <= '0;
      in_ready_q <= 1'b1;
    end else if (flush_i) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_ctrl  <= '0;
      skid_ctrl  <= '0;
      in_ready_q <= 1'b1;
    end else if (skid_valid) begin
      if (out_fire) begin
        main_valid <= 1'b1;
        main_ctrl  <= skid_ctrl;
        skid_valid <= 1'b0;
        skid_ctrl  <= '0;
        in_ready_q <= 1'b1;
      end
    end else if (!main_valid || out_fire) begin
      main_valid <= in_fire;
      main_ctrl  <= in_fire ? in_ctrl_i : '0;
    end else if (in_fire) begin
      skid_valid <= 1'b1;
      skid_ctrl  <= in_ctrl_i;
      in_ready_q <= 1'b0;
    end
  end

  // Payload registers: load on capture or skid transfer; cleared on
  // invalidation only when the zero-payload option is built in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_data <= '0;
      skid_data <= '0;
    end else if (flush_i) begin
      if (ZERO_PAYLOAD) begin
        main_data <= '0;
        skid_data <= '0;
      end
    end else if (skid_valid) begin
      if (out_fire) begin
        main_data <= skid_data;
        if (ZERO_PAYLOAD) skid_data <= '0;
      end
    end else if (!main_valid || out_fire) begin
      if (in_fire) main_data <= in_data_i;
      else if (ZERO_PAYLOAD) main_data <= '0;
    end else if (in_fire) begin
      skid_data <= in_data_i;
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = main_valid;
  assign out_ctrl_o  = main_ctrl;
  assign out_data_o  = main_data;
  assign occupancy_o = {1'b0, main_valid} + {1'b0, skid_valid};

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed plus short random bench for pipe_stage_skid, with a FIFO scoreboard
// of held entries: queue size is the expected occupancy.
module tb_pipe_stage_skid;
  localparam int unsigned CW = 8;
  localparam int unsigned DW = 128;

  typedef struct {
    logic [CW-1:0] c;
    logic [DW-1:0] d;
  } entry_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush_i = 1'b0;
  logic          in_valid_i = 1'b0;
  logic          in_ready_o;
  logic [CW-1:0] in_ctrl_i = '0;
  logic [DW-1:0] in_data_i = '0;
  logic          out_valid_o;
  logic          out_ready_i = 1'b0;
  logic [CW-1:0] out_ctrl_o;
  logic [DW-1:0] out_data_o;
  logic [1:0]    occupancy_o;

  int unsigned total = 0;
  int unsigned bad = 0;
  entry_t      sb[$];
  logic [DW-1:0] last_pop = '0;
  bit          acc;

  pipe_stage_skid #(.CTRL_WIDTH(CW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .in_ctrl_i(in_ctrl_i), .in_data_i(in_data_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_ctrl_o(out_ctrl_o), .out_data_o(out_data_o),
    .occupancy_o(occupancy_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] pay(input logic [CW-1:0] c);
    pay = {4{24'hC0FFEE, c}};
  endfunction

  // Compare all outputs against the scoreboard head.
  task automatic check_outputs();
    int unsigned n;
    n = sb.size();
    chk("out_valid", DW'(out_valid_o), DW'(n > 0));
    chk("in_ready", DW'(in_ready_o), DW'(n < 2));
    chk("occupancy", DW'(occupancy_o), DW'(n));
    if (n > 0) begin
      chk("out_ctrl", DW'(out_ctrl_o), DW'(sb[0].c));
      chk("out_data", out_data_o, sb[0].d);
    end else begin
      chk("bubble_ctrl", DW'(out_ctrl_o), '0);
    end
  endtask

  // One clock cycle: drive, check, clock, update scoreboard.
  task automatic cyc(input bit v, input logic [CW-1:0] c, input bit ordy,
                     input bit fl, output bit accepted);
    bit in_fire, out_fire;
    @(negedge clk);
    in_valid_i  = v;
    in_ctrl_i   = c;
    in_data_i   = pay(c);
    out_ready_i = ordy;
    flush_i     = fl;
    #1;
    check_outputs();
    in_fire  = v && (sb.size() < 2);
    out_fire = ordy && (sb.size() > 0);
    @(posedge clk);
    if (out_fire) last_pop = sb.pop_front().d;
    if (fl) sb.delete();
    else if (in_fire) sb.push_back('{c: c, d: pay(c)});
    accepted = in_fire && !fl;
  endtask

  // Keep offering one entry until accepted, with a cycle budget.
  task automatic push_until(input logic [CW-1:0] c, input bit ordy);
    bit a;
    int unsigned k;
    a = 1'b0;
    k = 0;
    while (!a && k < 20) begin
      cyc(1'b1, c, ordy, 1'b0, a);
      k++;
    end
    if (!a) chk("push_timeout", DW'(0), DW'(1));
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst_in_ready", DW'(in_ready_o), DW'(1));
    chk("rst_out_valid", DW'(out_valid_o), DW'(0));
    chk("rst_out_ctrl", DW'(out_ctrl_o), '0);
    chk("rst_out_data", out_data_o, '0);
    chk("rst_occupancy", DW'(occupancy_o), '0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1'b0, 8'h00, 1'b1, 1'b0, acc);
    cyc(1'b0, 8'h00, 1'b1, 1'b0, acc);

    // Streaming D0..D3 with downstream always ready
    for (int i = 0; i < 4; i++) cyc(1'b1, CW'(8'h11 + i), 1'b1, 1'b0, acc);
    cyc(1'b0, 8'h00, 1'b1, 1'b0, acc);
    cyc(1'b0, 8'h00, 1'b1, 1'b0, acc);
`ifdef PIPE_SKID_ZERO_PAYLOAD_EN
    chk("drain_data_zero", out_data_o, '0);
`else
    chk("drain_data_stale", out_data_o, pay(8'h14));
`endif

    // Backpressure: A to main, B to skid, C waits
    cyc(1'b1, 8'h21, 1'b0, 1'b0, acc);
    cyc(1'b1, 8'h22, 1'b0, 1'b0, acc);
    cyc(1'b1, 8'h23, 1'b0, 1'b0, acc);
    chk("bp_c_refused", DW'(acc), DW'(0));
    cyc(1'b1, 8'h23, 1'b0, 1'b0, acc);
    push_until(8'h23, 1'b1);
    for (int i = 0; i < 3; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0, acc);

    // Flush with full skid while upstream is offering an entry
    cyc(1'b1, 8'h31, 1'b0, 1'b0, acc);
    cyc(1'b1, 8'h32, 1'b0, 1'b0, acc);
    cyc(1'b1, 8'h3F, 1'b0, 1'b1, acc);
    cyc(1'b0, 8'h00, 1'b1, 1'b0, acc);
`ifdef PIPE_SKID_ZERO_PAYLOAD_EN
    chk("flush_data_zero", out_data_o, '0);
`endif
    // Flush with a real simultaneous input handshake
    cyc(1'b1, 8'h41, 1'b0, 1'b0, acc);
    cyc(1'b1, 8'h4F, 1'b0, 1'b1, acc);
    for (int i = 0; i < 2; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0, acc);

    // Flush together with an output handshake, then E
    cyc(1'b1, 8'h51, 1'b0, 1'b0, acc);
    cyc(1'b0, 8'h00, 1'b1, 1'b1, acc);
    chk("flush_consumed", last_pop, pay(8'h51));
    cyc(1'b1, 8'h5E, 1'b1, 1'b0, acc);
    cyc(1'b0, 8'h00, 1'b1, 1'b0, acc);
    chk("e_consumed", last_pop, pay(8'h5E));
    cyc(1'b0, 8'h00, 1'b1, 1'b0, acc);

    // Reset mid-operation
    cyc(1'b1, 8'h61, 1'b0, 1'b0, acc);
    cyc(1'b1, 8'h62, 1'b0, 1'b0, acc);
    @(negedge clk);
    in_valid_i = 1'b0;
    rst_n = 1'b0;
    #1;
    sb.delete();
    chk("mid_rst_data", out_data_o, '0);
    check_outputs();
    @(negedge clk);
    rst_n = 1'b1;

    // Random traffic
    for (int i = 0; i < 60; i++)
      cyc(1'($urandom_range(0, 1)), CW'($urandom), 1'($urandom_range(0, 1)),
          ($urandom_range(0, 15) == 0), acc);
    for (int i = 0; i < 3; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0, acc);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
